// File: rtl/readout_seq_pkg.sv
// Shared types and helpers for the row-readout sequencer.
package readout_seq_pkg;

    localparam int unsigned ROW_W_DEF = 9;
    localparam int unsigned T_W_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRECH  = 3'd1,
        SAMPR  = 3'd2,
        SETTLE = 3'd3,
        SAMPS  = 3'd4,
        READ   = 3'd5,
        GAP    = 3'd6,
        DONE   = 3'd7
    } seq_state_e;

    // Durations and row counts of zero behave as one.
    function automatic logic [31:0] clamp_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/readout_seq_phase_timer.sv
// Down-counting phase timer; last is high on the final cycle of a loaded phase.
module readout_seq_phase_timer #(
    parameter int unsigned T_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [T_W-1:0] load_val,
    output logic           last
);

    logic [T_W-1:0] cnt_q;

    // load_val is already clamped to >= 1, so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            last  <= 1'b0;
        end else if (load) begin
            cnt_q <= load_val;
            last  <= (load_val == T_W'(1));
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - T_W'(1);
            last  <= (cnt_q == T_W'(2));
        end
    end

endmodule

// File: rtl/readout_seq.sv
// Row-readout sequencer: on trigger, walks ROWADD over the frame and drives
// the per-row column strobes, holding re_busy for the whole frame.
module readout_seq
    import readout_seq_pkg::*;
#(
    parameter int unsigned ROW_W = ROW_W_DEF,
    parameter int unsigned T_W   = T_W_DEF
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             trigger_i,
    input  logic [ROW_W-1:0] NUM_ROW,
    input  logic [T_W-1:0]   T1,
    input  logic [T_W-1:0]   T2,
    input  logic [T_W-1:0]   T3,
    input  logic [T_W-1:0]   T4,
    input  logic [T_W-1:0]   T5,
    input  logic [T_W-1:0]   T6,
    output logic             re_busy,
    output logic [ROW_W-1:0] ROWADD,
    output logic             PRECH_COL,
    output logic             SAMP_R,
    output logic             SAMP_S,
    output logic             READ_S,
    output logic             MUX_START,
    output logic             frame_done,
    output logic             overrun
);

    seq_state_e       state_q, state_d;
    logic [ROW_W-1:0] row_d;
    logic [ROW_W-1:0] num_q;
    logic [T_W-1:0]   t1_q, t2_q, t3_q, t4_q, t5_q, t6_q;
    logic             pending_q;
    logic             capture_c;
    logic             load_c;
    logic [T_W-1:0]   load_val_c;
    logic             phase_last;

    readout_seq_phase_timer #(.T_W(T_W)) u_timer (
        .clk      (CLK),
        .rst_n    (rst_n),
        .load     (load_c),
        .load_val (load_val_c),
        .last     (phase_last)
    );

    // State register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, row advance and timer reload.
    always_comb begin
        state_d    = state_q;
        row_d      = ROWADD;
        capture_c  = 1'b0;
        load_c     = 1'b0;
        load_val_c = '0;
        case (state_q)
            IDLE: begin
                if (trigger_i || pending_q) begin
                    state_d    = PRECH;
                    row_d      = '0;
                    capture_c  = 1'b1;
                    load_c     = 1'b1;
                    load_val_c = T_W'(clamp_one(32'(T1)));
                end
            end
            PRECH:  if (phase_last) begin state_d = SAMPR;  load_c = 1'b1; load_val_c = t2_q; end
            SAMPR:  if (phase_last) begin state_d = SETTLE; load_c = 1'b1; load_val_c = t3_q; end
            SETTLE: if (phase_last) begin state_d = SAMPS;  load_c = 1'b1; load_val_c = t4_q; end
            SAMPS:  if (phase_last) begin state_d = READ;   load_c = 1'b1; load_val_c = t5_q; end
            READ:   if (phase_last) begin state_d = GAP;    load_c = 1'b1; load_val_c = t6_q; end
            GAP: begin
                if (phase_last) begin
                    if (ROWADD == num_q - ROW_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d    = PRECH;
                        row_d      = ROWADD + ROW_W'(1);
                        load_c     = 1'b1;
                        load_val_c = t1_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame parameters are frozen at acceptance.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            num_q <= '0;
            t1_q  <= '0;
            t2_q  <= '0;
            t3_q  <= '0;
            t4_q  <= '0;
            t5_q  <= '0;
            t6_q  <= '0;
        end else if (capture_c) begin
            num_q <= ROW_W'(clamp_one(32'(NUM_ROW)));
            t1_q  <= T_W'(clamp_one(32'(T1)));
            t2_q  <= T_W'(clamp_one(32'(T2)));
            t3_q  <= T_W'(clamp_one(32'(T3)));
            t4_q  <= T_W'(clamp_one(32'(T4)));
            t5_q  <= T_W'(clamp_one(32'(T5)));
            t6_q  <= T_W'(clamp_one(32'(T6)));
        end
    end

    // Triggers while busy collapse into one queued frame and flag overrun.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d == PRECH) pending_q <= 1'b0;
            else if (trigger_i && state_q != IDLE)  pending_q <= 1'b1;
            if (trigger_i && state_q != IDLE) overrun <= 1'b1;
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            re_busy    <= 1'b0;
            ROWADD     <= '0;
            PRECH_COL  <= 1'b0;
            SAMP_R     <= 1'b0;
            SAMP_S     <= 1'b0;
            READ_S     <= 1'b0;
            MUX_START  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            re_busy    <= (state_d != IDLE);
            ROWADD     <= row_d;
            PRECH_COL  <= (state_d == PRECH);
            SAMP_R     <= (state_d == SAMPR);
            SAMP_S     <= (state_d == SAMPS);
            READ_S     <= (state_d == READ);
            MUX_START  <= (state_d == READ) && (state_q != READ);
            frame_done <= (state_d == DONE);
        end
    end

endmodule
